// File: rtl/request_unit.sv
// request_unit
//   Memory request unit sitting between the MEM-stage pipeline latch and the
//   memory controller. A MEM-stage read/write enable is captured into
//   registers and presented to the controller as one stable data transaction.
//   Data has priority over instruction fetch. The unit also generates the
//   ihit/dhit strobes for the hazard unit and the sticky halt indication.
//
// Ports
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   memcuDRE   in   MEM-stage data read enable
//   memcuDWE   in   MEM-stage data write enable
//   memaddr    in   MEM-stage data address
//   memstore   in   MEM-stage store data
//   pc         in   fetch address
//   halt       in   halt instruction reached MEM stage
//   dwait      in   controller data busy
//   iwait      in   controller instruction busy
//   dREN/dWEN  out  data read/write request
//   daddr      out  registered data address
//   dstore     out  registered store word
//   iREN       out  instruction read request
//   iaddr      out  fetch address (pc)
//   dhit       out  data transaction completes this cycle
//   ihit       out  instruction fetch completes this cycle
//   halted     out  sticky halt indication
//   dstall_cnt out  data stall cycle count    (REQUNIT_STATS_EN only)
//   istall_cnt out  fetch stall cycle count   (REQUNIT_STATS_EN only)
//
// Build option
//   REQUNIT_STATS_EN : adds the dstall_cnt/istall_cnt counters and ports.

package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

module request_unit
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  memcuDRE,
    input  logic  memcuDWE,
    input  word_t memaddr,
    input  word_t memstore,
    input  word_t pc,
    input  logic  halt,
    input  logic  dwait,
    input  logic  iwait,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    output logic  iREN,
    output word_t iaddr,
    output logic  dhit,
    output logic  ihit,
`ifdef REQUNIT_STATS_EN
    output word_t dstall_cnt,
    output word_t istall_cnt,
`endif
    output logic  halted
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        HALTED
    } state_t;

    state_t r_state;
    state_t w_next_state;

    word_t  r_daddr;
    word_t  r_dstore;
    logic   r_is_read;
    logic   w_mem_req;

    assign w_mem_req = memcuDRE | memcuDWE;

    // State register and transaction capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_daddr   <= '0;
            r_dstore  <= '0;
            r_is_read <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_mem_req) begin
                r_daddr   <= memaddr;
                r_dstore  <= memstore;
                // DRE wins when both enables are set
                r_is_read <= memcuDRE;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                // A pending memory access is served before a halt is honoured
                if (w_mem_req)
                    w_next_state = BUSY;
                else if (halt)
                    w_next_state = HALTED;
            end
            BUSY: begin
                if (!dwait)
                    w_next_state = DONE;
            end
            DONE: begin
                // One idle cycle lets the pipeline latches advance so the
                // completed request is not seen again in IDLE.
                w_next_state = halt ? HALTED : IDLE;
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic; requests and strobes are gated by RST combinationally
    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        iREN   = 1'b0;
        dhit   = 1'b0;
        halted = 1'b0;
        unique case (r_state)
            IDLE:   iREN = 1'b1;
            BUSY: begin
                dREN = r_is_read;
                dWEN = !r_is_read;
                dhit = !dwait;
            end
            DONE:   iREN = 1'b1;
            HALTED: halted = 1'b1;
            default: ;
        endcase
        if (RST) begin
            dREN = 1'b0;
            dWEN = 1'b0;
            iREN = 1'b0;
            dhit = 1'b0;
        end
        ihit = iREN & !iwait;
    end

    assign daddr  = r_daddr;
    assign dstore = r_dstore;
    assign iaddr  = pc;

`ifdef REQUNIT_STATS_EN
    word_t r_dstall_cnt;
    word_t r_istall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dstall_cnt <= '0;
            r_istall_cnt <= '0;
        end else begin
            if (r_state == BUSY && dwait)
                r_dstall_cnt <= r_dstall_cnt + 32'd1;
            if (iREN && iwait)
                r_istall_cnt <= r_istall_cnt + 32'd1;
        end
    end

    assign dstall_cnt = r_dstall_cnt;
    assign istall_cnt = r_istall_cnt;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Testbench for request_unit. Inputs are driven on the falling edge, outputs
// are compared 1 ns later against a transaction-level reference model that
// tracks "access pending", "post-access gap" and "halted" conditions.

module tb_request_unit;

    logic        CLK;
    logic        RST;
    logic        memcuDRE;
    logic        memcuDWE;
    logic [31:0] memaddr;
    logic [31:0] memstore;
    logic [31:0] pc;
    logic        halt;
    logic        dwait;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dhit;
    logic        ihit;
    logic        halted;
`ifdef REQUNIT_STATS_EN
    logic [31:0] dstall_cnt;
    logic [31:0] istall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    request_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .memcuDRE (memcuDRE),
        .memcuDWE (memcuDWE),
        .memaddr  (memaddr),
        .memstore (memstore),
        .pc       (pc),
        .halt     (halt),
        .dwait    (dwait),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dhit     (dhit),
        .ihit     (ihit),
`ifdef REQUNIT_STATS_EN
        .dstall_cnt (dstall_cnt),
        .istall_cnt (istall_cnt),
`endif
        .halted   (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Observed output bundle: {dREN,dWEN,iREN,dhit,ihit,halted,daddr,dstore,iaddr}
    logic [101:0] obs;
    assign obs = {dREN, dWEN, iREN, dhit, ihit, halted, daddr, dstore, iaddr};

    // ---------------- reference model ----------------
    bit          m_pending  = 0;   // an access is outstanding at the controller
    bit          m_gap      = 0;   // cycle after an access completed
    bit          m_halted   = 0;
    bit          m_read     = 0;
    logic [31:0] m_addr     = '0;
    logic [31:0] m_store    = '0;
    int unsigned m_dstall   = 0;
    int unsigned m_istall   = 0;

    function automatic logic [101:0] expected();
        logic rd, wr, ir, dh, ih;
        rd = m_pending && m_read && !RST;
        wr = m_pending && !m_read && !RST;
        ir = !RST && !m_pending && !m_halted;
        dh = m_pending && !dwait && !RST;
        ih = ir && !iwait;
        return {rd, wr, ir, dh, ih, m_halted, m_addr, m_store, pc};
    endfunction

    task automatic model_update();
        logic ir;
        ir = !RST && !m_pending && !m_halted;
        if (RST) begin
            m_pending = 0; m_gap = 0; m_halted = 0; m_read = 0;
            m_addr = '0; m_store = '0; m_dstall = 0; m_istall = 0;
        end else begin
            if (m_pending && dwait) m_dstall++;
            if (ir && iwait)        m_istall++;
            if (m_halted) begin
            end else if (m_pending) begin
                if (!dwait) begin m_pending = 0; m_gap = 1; end
            end else if (m_gap) begin
                m_gap = 0;
                m_halted = halt;
            end else if (memcuDRE || memcuDWE) begin
                m_pending = 1;
                m_read    = memcuDRE;
                m_addr    = memaddr;
                m_store   = memstore;
            end else if (halt) begin
                m_halted = 1;
            end
        end
    endtask

    // Advance one clock: model follows the edge, then return at next negedge.
    task automatic step();
        model_update();
        @(negedge CLK);
    endtask

    task automatic set_in(input bit rst, input bit dre, input bit dwe,
                          input logic [31:0] a, input logic [31:0] s,
                          input bit h, input bit dw, input bit iw);
        RST = rst; memcuDRE = dre; memcuDWE = dwe; memaddr = a; memstore = s;
        halt = h; dwait = dw; iwait = iw; pc = $urandom;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, '0, '0, 0, 0, 0);
        #1;
        step();
        set_in(0, 0, 0, '0, '0, 0, 0, 0);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, $urandom_range(0,1), $urandom_range(0,1), $urandom, $urandom, 0, 0, 0);
            #1;
            checks++;
            if ({dREN, dWEN, iREN, dhit, ihit} !== 5'b0) begin
                failures++;
                $display("FAIL reset_gating: got %b expected 00000", {dREN, dWEN, iREN, dhit, ihit});
            end
            step();
        end
        set_in(0, 0, 0, $urandom, $urandom, 0, 0, 0);
        #1;
        checks++;
        if ({dREN, dWEN, iREN, halted, daddr, dstore, iaddr} !== {4'b0010, 64'd0, pc}) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h",
                     {dREN, dWEN, iREN, halted, daddr, dstore, iaddr}, {4'b0010, 64'd0, pc});
        end
        step();
    endtask

    task automatic test_zero_wait_load();
        do_reset();
        set_in(0, 1, 0, 32'h100, $urandom, 0, 0, 0);
        #1;
        step();
        set_in(0, 0, 0, $urandom, $urandom, 0, 0, 0);
        #1;
        checks++;
        if ({dREN, dWEN, dhit, iREN, daddr} !== {4'b1010, 32'h100}) begin
            failures++;
            $display("FAIL load_busy: got %h expected %h", {dREN, dWEN, dhit, iREN, daddr}, {4'b1010, 32'h100});
        end
        step();
        #1;
        checks++;
        if ({dREN, dhit, iREN} !== 3'b001) begin
            failures++;
            $display("FAIL load_done: got %b expected 001", {dREN, dhit, iREN});
        end
        step();
        #1;
        checks++;
        if (obs !== expected()) begin
            failures++;
            $display("FAIL load_idle: got %h expected %h", obs, expected());
        end
        step();
    endtask

    task automatic test_store_wait();
        do_reset();
        set_in(0, 0, 1, $urandom, 32'hDEADBEEF, 0, 1, 0);
        #1;
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, $urandom, (i == 1) ? 32'h12345678 : $urandom, 0, (i < 3), 0);
            #1;
            checks++;
            if ({dWEN, dREN, iREN, dhit, dstore} !== {3'b100, (i == 3), 32'hDEADBEEF}) begin
                failures++;
                $display("FAIL store_wait[%0d]: got %h expected %h", i,
                         {dWEN, dREN, iREN, dhit, dstore}, {3'b100, (i == 3), 32'hDEADBEEF});
            end
            step();
        end
        #1;
        checks++;
        if (obs !== expected() || dWEN !== 1'b0) begin
            failures++;
            $display("FAIL store_done: got %h expected %h", obs, expected());
        end
        step();
    endtask

    task automatic test_conflict();
        do_reset();
        set_in(0, 1, 1, 32'hABC0, 32'h5555, 0, 0, 0);
        #1;
        step();
        set_in(0, 0, 0, $urandom, $urandom, 0, 0, 0);
        #1;
        checks++;
        if ({dREN, dWEN} !== 2'b10) begin
            failures++;
            $display("FAIL conflict_read: got %b expected 10", {dREN, dWEN});
        end
        step();
    endtask

    task automatic test_halt();
        do_reset();
        set_in(0, 0, 0, $urandom, $urandom, 1, 0, 0);
        #1;
        step();
        for (int i = 0; i < 5; i++) begin
            set_in(0, $urandom_range(0,1), $urandom_range(0,1), $urandom, $urandom, 0,
                   $urandom_range(0,1), $urandom_range(0,1));
            #1;
            checks++;
            if ({halted, dREN, dWEN, iREN, dhit, ihit} !== 6'b100000) begin
                failures++;
                $display("FAIL halt_hold[%0d]: got %b expected 100000", i, {halted, dREN, dWEN, iREN, dhit, ihit});
            end
            step();
        end
        do_reset();
        checks++;
        if ({halted, iREN} !== 2'b01) begin
            failures++;
            $display("FAIL halt_release: got %b expected 01", {halted, iREN});
        end
    endtask

    task automatic test_halt_with_access();
        do_reset();
        set_in(0, 0, 1, 32'h44, 32'h99, 1, 0, 0);
        #1;
        step();
        set_in(0, 0, 0, $urandom, $urandom, 1, 0, 0);
        #1;
        checks++;
        if ({dWEN, dhit, halted} !== 3'b110) begin
            failures++;
            $display("FAIL halt_access_first: got %b expected 110", {dWEN, dhit, halted});
        end
        step();
        #1;
        step();
        #1;
        checks++;
        if ({halted, iREN} !== 2'b10) begin
            failures++;
            $display("FAIL halt_after_done: got %b expected 10", {halted, iREN});
        end
        do_reset();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        set_in(0, 1, 0, 32'h200, $urandom, 0, 1, 0);
        #1;
        step();
        set_in(0, 0, 0, $urandom, $urandom, 0, 1, 0);
        #1;
        step();
        set_in(1, 0, 0, $urandom, $urandom, 0, 0, 0);
        #1;
        checks++;
        if ({dREN, dhit} !== 2'b00) begin
            failures++;
            $display("FAIL rst_busy_drop: got %b expected 00", {dREN, dhit});
        end
        step();
        set_in(0, 0, 0, $urandom, $urandom, 0, 0, 0);
        #1;
        checks++;
        if ({dREN, iREN, daddr} !== {2'b01, 32'd0}) begin
            failures++;
            $display("FAIL rst_busy_idle: got %h expected %h", {dREN, iREN, daddr}, {2'b01, 32'd0});
        end
        step();
    endtask

`ifdef REQUNIT_STATS_EN
    task automatic test_stats();
        do_reset();
        set_in(0, 1, 0, $urandom, $urandom, 0, 1, 0);
        #1;
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, $urandom, $urandom, 0, (i < 5), 0);
            #1;
            step();
        end
        #1;
        checks++;
        if (dstall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL dstall_cnt: got %0d expected 5", dstall_cnt);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, $urandom, $urandom, 0, 0, (i < 2));
            #1;
            step();
        end
        #1;
        checks++;
        if (istall_cnt !== 32'd2) begin
            failures++;
            $display("FAIL istall_cnt: got %0d expected 2", istall_cnt);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0,39) == 0), ($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0),
                   $urandom, $urandom, ($urandom_range(0,29) == 0),
                   $urandom_range(0,1), ($urandom_range(0,9) < 3));
            #1;
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, expected());
            end
`ifdef REQUNIT_STATS_EN
            checks++;
            if ({dstall_cnt, istall_cnt} !== {m_dstall, m_istall}) begin
                failures++;
                $display("FAIL random_stats[%0d]: got %h expected %h", i,
                         {dstall_cnt, istall_cnt}, {m_dstall, m_istall});
            end
`endif
            step();
        end
    endtask

    initial begin
        set_in(1, 0, 0, '0, '0, 0, 0, 0);
        @(negedge CLK);
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_conflict();
        test_halt();
        test_halt_with_access();
        test_reset_mid_access();
`ifdef REQUNIT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
